// File: rtl/rp_reconfig_ctrl_if.sv
// rtl/rp_reconfig_ctrl_if.sv - request, configuration-port and per-RP control signals of the reconfiguration controller
interface rp_reconfig_ctrl_if;
   logic [1:0] req_i;
   logic       load_done_i;
   logic       load_err_i;
   logic       load_start_o;
   logic [1:0] grant_o;
   logic [1:0] decouple_o;
   logic [1:0] rp_rst_o;
   logic       busy_o;
   logic [1:0] err_o;

   // controller side
   modport master (
      input  req_i, load_done_i, load_err_i,
      output load_start_o, grant_o, decouple_o, rp_rst_o, busy_o, err_o
   );

   // requester / configuration-port side
   modport slave (
      output req_i, load_done_i, load_err_i,
      input  load_start_o, grant_o, decouple_o, rp_rst_o, busy_o, err_o
   );
endinterface

// File: rtl/rp_reconfig_ctrl.sv
// rtl/rp_reconfig_ctrl.sv - two-RP partial reconfiguration sequencer; optional load watchdog under RP_LOAD_TIMEOUT_EN
module rp_reconfig_ctrl #(
   parameter int DRAIN_CYC   = 16,
   parameter int RST_CYC     = 8,
   parameter int TIMEOUT_CYC = 1048576
) (
   input logic                  clk100,
   input logic                  rst,
   rp_reconfig_ctrl_if.master   ctrl_bus
);

   localparam int CNT_MAX_A = (DRAIN_CYC > RST_CYC) ? DRAIN_CYC : RST_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, DRAIN, LOAD, RESET, RELEASE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_en;
   logic             r_ptr;
   logic             r_sel;
   logic             w_sel;
   logic             w_load_fail;
   logic             r_load_start;
   logic             r_busy;
   logic [1:0]       r_grant;
   logic [1:0]       r_decouple;
   logic [1:0]       r_rp_rst;
   logic [1:0]       r_err;

`ifdef RP_LOAD_TIMEOUT_EN
   logic             w_timeout;
   assign w_timeout = (r_state == LOAD) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign w_cnt_en  = (r_state == DRAIN) || (r_state == LOAD) || (r_state == RESET);
`else
   assign w_cnt_en  = (r_state == DRAIN) || (r_state == RESET);
`endif

   assign ctrl_bus.load_start_o = r_load_start;
   assign ctrl_bus.grant_o      = r_grant;
   assign ctrl_bus.decouple_o   = r_decouple;
   assign ctrl_bus.rp_rst_o     = r_rp_rst;
   assign ctrl_bus.busy_o       = r_busy;
   assign ctrl_bus.err_o        = r_err;

   // round-robin pick: a lone request always wins, a tie goes to the pointer
   always_comb begin
      w_sel = r_ptr;
      case (ctrl_bus.req_i)
         2'b01:   w_sel = 1'b0;
         2'b10:   w_sel = 1'b1;
         default: w_sel = r_ptr;
      endcase
   end

   // next-state; a simultaneous done+err is treated as a failed load
   always_comb begin
      w_state_nxt = r_state;
      w_load_fail = 1'b0;
      case (r_state)
         IDLE: begin
            if (|ctrl_bus.req_i) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (r_cnt == CNT_W'(DRAIN_CYC - 1)) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (ctrl_bus.load_done_i || ctrl_bus.load_err_i) begin
               w_state_nxt = RESET;
               w_load_fail = ctrl_bus.load_err_i;
            end
`ifdef RP_LOAD_TIMEOUT_EN
            else if (w_timeout) begin
               w_state_nxt = RESET;
               w_load_fail = 1'b1;
            end
`endif
         end
         RESET: begin
            if (r_cnt == CNT_W'(RST_CYC - 1)) w_state_nxt = RELEASE;
         end
         RELEASE: begin
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // state register and per-state cycle counter, cleared on every state change
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state) r_cnt <= '0;
         else if (w_cnt_en)          r_cnt <= r_cnt + 1'b1;
      end
   end

   // registered outputs; only the selected RP's bits are ever touched
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         r_ptr        <= 1'b0;
         r_sel        <= 1'b0;
         r_load_start <= 1'b0;
         r_busy       <= 1'b0;
         r_grant      <= 2'b00;
         r_decouple   <= 2'b00;
         r_rp_rst     <= 2'b00;
         r_err        <= 2'b00;
      end else begin
         r_load_start <= 1'b0;
         r_busy       <= (w_state_nxt != IDLE);
         case (r_state)
            IDLE: begin
               if (w_state_nxt == DRAIN) begin
                  r_sel             <= w_sel;
                  r_grant           <= {w_sel, ~w_sel};
                  r_decouple[w_sel] <= 1'b1;
                  r_err[w_sel]      <= 1'b0;
               end
            end
            DRAIN: begin
               if (w_state_nxt == LOAD) r_load_start <= 1'b1;
            end
            LOAD: begin
               if (w_state_nxt == RESET) begin
                  r_rp_rst[r_sel] <= 1'b1;
                  if (w_load_fail) r_err[r_sel] <= 1'b1;
               end
            end
            RESET: begin
               // a failed RP stays in reset until a later good load
               if ((w_state_nxt == RELEASE) && !r_err[r_sel]) r_rp_rst[r_sel] <= 1'b0;
            end
            RELEASE: begin
               r_grant <= 2'b00;
               r_ptr   <= ~r_sel;
               if (!r_err[r_sel]) r_decouple[r_sel] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rp_reconfig_ctrl.sv
// tb/tb_rp_reconfig_ctrl.sv - scoreboard bench for rp_reconfig_ctrl
module tb_rp_reconfig_ctrl;

   logic clk100 = 1'b0;
   logic rst    = 1'b1;

   always #5 clk100 = ~clk100;

   rp_reconfig_ctrl_if bus ();

   rp_reconfig_ctrl #(
      .DRAIN_CYC   (4),
      .RST_CYC     (2),
      .TIMEOUT_CYC (8)
   ) u_dut (
      .clk100   (clk100),
      .rst      (rst),
      .ctrl_bus (bus)
   );

   int         n_chk = 0;
   int         n_bad = 0;
   logic [1:0] q_grant[$];
   logic [5:0] q_end[$];
   logic       m_prev_gnt  = 1'b0;
   logic       m_prev_busy = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {bus.grant_o, bus.decouple_o, bus.rp_rst_o, bus.err_o, bus.load_start_o, bus.busy_o};
   endfunction

   // monitor: pop expected grant on each new grant, expected RP state on each return to idle
   always @(negedge clk100) begin
      logic [1:0] e_g;
      logic [5:0] e_end;
      if (!m_prev_gnt && (bus.grant_o != 2'b00)) begin
         if (q_grant.size() == 0) check_eq("grant_extra", bus.grant_o, 2'b00);
         else begin
            e_g = q_grant.pop_front();
            check_eq("grant", bus.grant_o, e_g);
         end
      end
      if (m_prev_busy && !bus.busy_o) begin
         if (q_end.size() == 0) check_eq("end_extra", 1, 0);
         else begin
            e_end = q_end.pop_front();
            check_eq("end_state", {bus.decouple_o, bus.rp_rst_o, bus.err_o}, e_end);
         end
      end
      m_prev_gnt  = (bus.grant_o != 2'b00);
      m_prev_busy = bus.busy_o;
   end

   task automatic tick();
      @(posedge clk100);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.req_i       = 2'b00;
      bus.load_done_i = 1'b0;
      bus.load_err_i  = 1'b0;
      repeat (3) @(posedge clk100);
      @(negedge clk100);
      check_eq("rst_outs", outs(), 10'h0);
      tick();
      rst = 1'b0;
   endtask

   // wait for load_start, then answer after lat cycles with the given done/err pulse
   task automatic serve(input int lat, input logic d, input logic e);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk100);
         if (bus.load_start_o) seen = 1'b1;
      end
      check_eq("load_start_seen", seen, 1);
      if (seen) begin
         repeat (lat) tick();
         bus.load_done_i = d;
         bus.load_err_i  = e;
         tick();
         bus.load_done_i = 1'b0;
         bus.load_err_i  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         @(negedge clk100);
         if (!bus.busy_o) idle = 1'b1;
      end
      check_eq("idle_reached", idle, 1);
   endtask

   initial begin
      bit seen;
      bus.req_i       = 2'b00;
      bus.load_done_i = 1'b0;
      bus.load_err_i  = 1'b0;

      // cycle-exact single RP0 sequence with stray done/err outside LOAD
      do_reset();
      q_grant.push_back(2'b01);
      q_end.push_back(6'b00_00_00);
      for (int c = 0; c < 16; c++) begin
         logic [1:0] e_g;
         logic [1:0] e_r;
         bus.req_i       = (c == 0) ? 2'b01 : 2'b00;
         bus.load_done_i = (c == 0) || (c == 2) || (c == 10) || (c == 14);
         bus.load_err_i  = (c == 3);
         e_g = (c >= 1 && c <= 13) ? 2'b01 : 2'b00;
         e_r = (c == 11 || c == 12) ? 2'b01 : 2'b00;
         @(negedge clk100);
         check_eq($sformatf("seq1_c%0d", c), outs(),
                  {e_g, e_g, e_r, 2'b00, (c == 5), (c >= 1 && c <= 13)});
         tick();
      end
      bus.load_done_i = 1'b0;
      bus.load_err_i  = 1'b0;

      // both requesting from reset: RP0, RP1, RP0 with one idle cycle between
      do_reset();
      q_grant.push_back(2'b01);
      q_grant.push_back(2'b10);
      q_grant.push_back(2'b01);
      repeat (3) q_end.push_back(6'b00_00_00);
      bus.req_i = 2'b11;
      for (int s = 0; s < 3; s++) begin
         serve(3, 1'b1, 1'b0);
         if (s == 2) bus.req_i = 2'b00;
         wait_idle();
         @(negedge clk100);
         check_eq($sformatf("idle_gap%0d", s), bus.busy_o, (s < 2));
      end

      // RP1 done+err together -> error state held; RP0 sequence leaves RP1 bits alone
      bus.req_i = 2'b10;
      q_grant.push_back(2'b10);
      q_end.push_back(6'b10_10_10);
      serve(2, 1'b1, 1'b1);
      bus.req_i = 2'b00;
      wait_idle();
      bus.req_i = 2'b01;
      q_grant.push_back(2'b01);
      q_end.push_back(6'b10_10_10);
      serve(3, 1'b1, 1'b0);
      bus.req_i = 2'b00;
      wait_idle();
      // later good RP1 load clears the error
      bus.req_i = 2'b10;
      q_grant.push_back(2'b10);
      q_end.push_back(6'b00_00_00);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk100);
         if (bus.busy_o) seen = 1'b1;
      end
      check_eq("drain_entry", {seen, bus.decouple_o, bus.err_o}, {1'b1, 2'b10, 2'b00});
      serve(2, 1'b1, 1'b0);
      bus.req_i = 2'b00;
      wait_idle();

      // reset during RESET of RP0
      do_reset();
      bus.req_i = 2'b11;
      q_grant.push_back(2'b01);
      serve(2, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk100);
         if (bus.rp_rst_o[0]) seen = 1'b1;
      end
      check_eq("in_reset_state", seen, 1);
      q_end.push_back(6'b00_00_00);
      rst = 1'b1;
      #1;
      check_eq("rst_async", outs(), 10'h0);
      tick();
      tick();
      q_grant.push_back(2'b01);
      q_end.push_back(6'b00_00_00);
      rst = 1'b0;
      serve(2, 1'b1, 1'b0);
      bus.req_i = 2'b00;
      wait_idle();

      // no done at all
      bus.req_i = 2'b01;
      q_grant.push_back(2'b01);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk100);
         if (bus.load_start_o) seen = 1'b1;
      end
      check_eq("tmo_start", seen, 1);
      bus.req_i = 2'b00;
`ifdef RP_LOAD_TIMEOUT_EN
      q_end.push_back(6'b01_01_01);
      repeat (7) @(negedge clk100);
      check_eq("tmo_early", bus.err_o, 2'b00);
      @(negedge clk100);
      check_eq("tmo_err", bus.err_o, 2'b01);
      wait_idle();
`else
      q_end.push_back(6'b00_00_00);
      repeat (1000) @(negedge clk100);
      check_eq("load_wait", {bus.busy_o, bus.load_start_o, bus.rp_rst_o}, {1'b1, 1'b0, 2'b00});
      tick();
      bus.load_done_i = 1'b1;
      tick();
      bus.load_done_i = 1'b0;
      wait_idle();
`endif

      repeat (3) @(negedge clk100);
      check_eq("sb_left", q_grant.size() + q_end.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
